// File: rtl/race_pkg.sv
// race_pkg: shared definitions for the race controller.
//   race_state_e : encoding of the race state presented on race_ctrl.state
//   LIGHTS_GO    : lamp count that ends the countdown
package race_pkg;

    typedef enum logic [1:0] {
        RACE_IDLE      = 2'd0,
        RACE_COUNTDOWN = 2'd1,
        RACE_RACE      = 2'd2,
        RACE_FINISH    = 2'd3
    } race_state_e;

    localparam logic [1:0] LIGHTS_GO = 2'd3;

endpackage

// File: rtl/race_lane.sv
// race_lane: one player's lane state (gear, track position, false-start flag).
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : synchronous clear of pos/gear/dq (race start or abort)
//   count_en      : countdown in progress; a shift marks a false start
//   race_en       : race in progress; shifts raise the gear, ticks move the car
//   tick, shift   : frame pulse and this player's gear-up pulse
//   pos, gear, dq : registered lane state
//   dq_next       : value dq will take at the next edge
//   hit           : this lane reaches the finish at the next edge
module race_lane #(
    parameter int POS_W     = 11,
    parameter int TRACK_LEN = 768,
    parameter int GEAR_MAX  = 5,
    parameter int GW        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic             race_en,
    input  logic             tick,
    input  logic             shift,
    output logic [POS_W-1:0] pos,
    output logic [GW-1:0]    gear,
    output logic             dq,
    output logic             dq_next,
    output logic             hit
);

    localparam logic [POS_W-1:0] TRACK_TOP = POS_W'(TRACK_LEN);
    localparam logic [GW-1:0]    GEAR_TOP  = GW'(GEAR_MAX);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [GW-1:0]    gear_q, gear_d;
    logic             dq_q, dq_d;
    logic [POS_W:0]   sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pos_d  = pos_q;
        gear_d = gear_q;
        dq_d   = dq_q;
        hit    = 1'b0;
        // One extra bit so pos + gear can never wrap before the clamp.
        sum    = {1'b0, pos_q} + (POS_W + 1)'(gear_q);
        if (clear) begin
            pos_d  = '0;
            gear_d = '0;
            dq_d   = 1'b0;
        end else if (count_en) begin
            if (shift) dq_d = 1'b1;
        end else if (race_en && !dq_q) begin
            // Movement uses the gear held before any same-cycle shift.
            if (tick) begin
                pos_d = (sum >= {1'b0, TRACK_TOP}) ? TRACK_TOP : sum[POS_W-1:0];
                hit   = (pos_d == TRACK_TOP);
            end
            if (shift && gear_q != GEAR_TOP) gear_d = gear_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q  <= '0;
            gear_q <= '0;
            dq_q   <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            gear_q <= gear_d;
            dq_q   <= dq_d;
        end
    end

    assign pos     = pos_q;
    assign gear    = gear_q;
    assign dq      = dq_q;
    assign dq_next = dq_d;

endmodule

// File: rtl/race_ctrl.sv
// race_ctrl: drag-race sequencer. Runs the lamp countdown, owns one race_lane
// per player and picks the lowest-index lane that reaches the finish.
//   clk, rst      : pixel clock, asynchronous active-low reset
//   start, abort  : menu pulses (abort wins over everything)
//   frame_tick    : one pulse per frame
//   shift         : per-player gear-up pulses
//   state, lights : race state and lit countdown lamps
//   pos, gear, dq : packed per-lane position, gear and false-start flag
//   winner, winner_valid : result, valid in FINISH when someone finished
module race_ctrl
    import race_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int POS_W       = 11,
    parameter int TRACK_LEN   = 768,
    parameter int GEAR_MAX    = 5,
    parameter int COUNT_TICKS = 60,
    localparam int GW = $clog2(GEAR_MAX + 1),
    localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         frame_tick,
    input  logic [NUM_PLAYERS-1:0]       shift,
    output logic [1:0]                   state,
    output logic [1:0]                   lights,
    output logic [NUM_PLAYERS*POS_W-1:0] pos,
    output logic [NUM_PLAYERS*GW-1:0]    gear,
    output logic [NUM_PLAYERS-1:0]       dq,
    output logic [WW-1:0]                winner,
    output logic                         winner_valid
);

    localparam int            CW       = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_TICKS - 1);

    race_state_e      state_q, state_d;
    logic [1:0]       lights_q, lights_d;
    logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [WW-1:0]    winner_q, winner_d;
    logic             winner_valid_q, winner_valid_d;

    logic                   clear_lanes;
    logic                   count_en;
    logic                   race_en;
    logic [NUM_PLAYERS-1:0] hit;
    logic [NUM_PLAYERS-1:0] dq_next;
    logic [WW-1:0]          first_hit;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
        race_lane #(
            .POS_W     (POS_W),
            .TRACK_LEN (TRACK_LEN),
            .GEAR_MAX  (GEAR_MAX),
            .GW        (GW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear_lanes),
            .count_en (count_en),
            .race_en  (race_en),
            .tick     (frame_tick),
            .shift    (shift[i]),
            .pos      (pos[i*POS_W +: POS_W]),
            .gear     (gear[i*GW +: GW]),
            .dq       (dq[i]),
            .dq_next  (dq_next[i]),
            .hit      (hit[i])
        );
    end

    // Scan from the top down so the lowest finishing index is kept.
    always_comb begin
        first_hit = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (hit[i]) first_hit = WW'(i);
        end
    end

    assign count_en = (state_q == RACE_COUNTDOWN);
    assign race_en  = (state_q == RACE_RACE);

    always_comb begin
        state_d        = state_q;
        lights_d       = lights_q;
        tick_cnt_d     = tick_cnt_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        clear_lanes    = 1'b0;
        if (abort) begin
            state_d        = RACE_IDLE;
            lights_d       = '0;
            tick_cnt_d     = '0;
            winner_d       = '0;
            winner_valid_d = 1'b0;
            clear_lanes    = 1'b1;
        end else begin
            unique case (state_q)
                RACE_IDLE, RACE_FINISH: begin
                    // The previous winner index is left in place; only its valid flag drops.
                    if (start) begin
                        state_d        = RACE_COUNTDOWN;
                        lights_d       = '0;
                        tick_cnt_d     = '0;
                        winner_valid_d = 1'b0;
                        clear_lanes    = 1'b1;
                    end
                end
                RACE_COUNTDOWN: begin
                    if (frame_tick) begin
                        if (tick_cnt_q == CNT_LAST) begin
                            tick_cnt_d = '0;
                            if (lights_q == LIGHTS_GO) begin
                                // Nobody left to race: skip straight to the result.
                                state_d = (&dq_next) ? RACE_FINISH : RACE_RACE;
                            end else begin
                                lights_d = lights_q + 2'd1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end
                    end
                end
                RACE_RACE: begin
                    if (|hit) begin
                        state_d        = RACE_FINISH;
                        winner_d       = first_hit;
                        winner_valid_d = 1'b1;
                    end
                end
                default: state_d = RACE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RACE_IDLE;
            lights_q       <= '0;
            tick_cnt_q     <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lights_q       <= lights_d;
            tick_cnt_q     <= tick_cnt_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
        end
    end

    assign state        = state_q;
    assign lights       = lights_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_race_ctrl.sv
// tb_race_ctrl: directed scenarios plus a randomized run against a
// behavioural race model for race_ctrl (2-lane and 4-lane instances).
module tb_race_ctrl;

    localparam int CT = 2;
    localparam int TL = 20;
    localparam int GM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Two-lane instance
    logic        start_a = 0, abort_a = 0, tick_a = 0;
    logic [1:0]  shift_a = '0;
    logic [1:0]  state_a, lights_a;
    logic [21:0] pos_a;
    logic [5:0]  gear_a;
    logic [1:0]  dq_a;
    logic [0:0]  winner_a;
    logic        wv_a;

    race_ctrl #(.NUM_PLAYERS(2), .POS_W(11), .TRACK_LEN(TL), .GEAR_MAX(GM), .COUNT_TICKS(CT)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .frame_tick(tick_a),
        .shift(shift_a), .state(state_a), .lights(lights_a), .pos(pos_a), .gear(gear_a),
        .dq(dq_a), .winner(winner_a), .winner_valid(wv_a));

    // Four-lane instance
    logic        start_b = 0, abort_b = 0, tick_b = 0;
    logic [3:0]  shift_b = '0;
    logic [1:0]  state_b, lights_b;
    logic [43:0] pos_b;
    logic [11:0] gear_b;
    logic [3:0]  dq_b;
    logic [1:0]  winner_b;
    logic        wv_b;

    race_ctrl #(.NUM_PLAYERS(4), .POS_W(11), .TRACK_LEN(TL), .GEAR_MAX(GM), .COUNT_TICKS(CT)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .frame_tick(tick_b),
        .shift(shift_b), .state(state_b), .lights(lights_b), .pos(pos_b), .gear(gear_b),
        .dq(dq_b), .winner(winner_b), .winner_valid(wv_b));

    // Behavioural model of the two-lane race: countdown tracked as ticks since start.
    int m_state, m_ticks, m_win, m_wv;
    int m_pos[2], m_gear[2], m_dq[2];

    task automatic model_reset();
        m_state = 0; m_ticks = 0; m_win = 0; m_wv = 0;
        for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_gear[i] = 0; m_dq[i] = 0; end
    endtask

    task automatic model_step(input logic st, input logic ab, input logic tk, input logic [1:0] sh);
        if (ab) begin
            model_reset();
        end else if (m_state == 0 || m_state == 3) begin
            if (st) begin
                m_state = 1; m_ticks = 0; m_wv = 0;
                for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_gear[i] = 0; m_dq[i] = 0; end
            end
        end else if (m_state == 1) begin
            for (int i = 0; i < 2; i++) if (sh[i]) m_dq[i] = 1;
            if (tk) begin
                m_ticks++;
                if (m_ticks == 4 * CT) m_state = (m_dq[0] == 1 && m_dq[1] == 1) ? 3 : 2;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_dq[i] == 0) begin
                    if (tk) m_pos[i] = (m_pos[i] + m_gear[i] > TL) ? TL : m_pos[i] + m_gear[i];
                    if (sh[i] && m_gear[i] < GM) m_gear[i]++;
                end
            end
            if (tk) begin
                for (int i = 1; i >= 0; i--) begin
                    if (m_dq[i] == 0 && m_pos[i] == TL) begin
                        m_state = 3; m_win = i; m_wv = 1;
                    end
                end
            end
        end
    endtask

    function automatic int model_lights();
        if (m_state == 0) return 0;
        return (m_ticks / CT > 3) ? 3 : m_ticks / CT;
    endfunction

    task automatic pulse_a(input logic st, input logic ab, input logic tk, input logic [1:0] sh);
        start_a = st; abort_a = ab; tick_a = tk; shift_a = sh;
        model_step(st, ab, tk, sh);
        @(posedge clk); #1;
        start_a = 0; abort_a = 0; tick_a = 0; shift_a = '0;
    endtask

    task automatic pulse_b(input logic st, input logic tk, input logic [3:0] sh);
        start_b = st; tick_b = tk; shift_b = sh;
        @(posedge clk); #1;
        start_b = 0; tick_b = 0; shift_b = '0;
    endtask

    task automatic countdown_a();
        pulse_a(1, 0, 0, 2'b00);
        for (int k = 0; k < 4 * CT; k++) pulse_a(0, 0, 1, 2'b00);
    endtask

    task automatic test_reset();
        total++;
        if ({state_a, lights_a, pos_a, gear_a, dq_a, winner_a, wv_a} !== '0) begin
            bad++; $display("FAIL reset_a: got state=%0d lights=%0d pos=%h gear=%h dq=%b win=%0d wv=%b, want all zero",
                            state_a, lights_a, pos_a, gear_a, dq_a, winner_a, wv_a);
        end
        total++;
        if ({state_b, lights_b, pos_b, gear_b, dq_b, winner_b, wv_b} !== '0) begin
            bad++; $display("FAIL reset_b: got state=%0d pos=%h gear=%h, want all zero", state_b, pos_b, gear_b);
        end
    endtask

    task automatic test_countdown();
        pulse_a(1, 0, 0, 2'b00);
        total++;
        if (state_a !== 2'd1 || lights_a !== 2'd0) begin
            bad++; $display("FAIL cd_entry: state=%0d lights=%0d, want 1 0", state_a, lights_a);
        end
        for (int k = 1; k <= 8; k++) begin
            pulse_a(0, 0, 1, 2'b00);
            total++;
            if (lights_a !== 2'((k < 8) ? k / 2 : 3) || state_a !== 2'((k < 8) ? 1 : 2)) begin
                bad++; $display("FAIL cd_tick%0d: lights=%0d state=%0d, want %0d %0d",
                                k, lights_a, state_a, (k < 8) ? k / 2 : 3, (k < 8) ? 1 : 2);
            end
        end
        total++;
        if (dq_a !== 2'b00) begin bad++; $display("FAIL cd_dq: dq=%b, want 00", dq_a); end
    endtask

    task automatic test_race();
        for (int k = 0; k < 4; k++) pulse_a(0, 0, 0, 2'b01);
        for (int k = 0; k < 2; k++) pulse_a(0, 0, 0, 2'b10);
        total++;
        if (gear_a !== {3'd2, 3'd4}) begin bad++; $display("FAIL race_gears: gear=%h, want %h", gear_a, {3'd2, 3'd4}); end
        for (int k = 1; k <= 5; k++) begin
            pulse_a(0, 0, 1, 2'b00);
            total++;
            if (pos_a[10:0] !== 11'(4 * k) || state_a !== 2'((k < 5) ? 2 : 3)) begin
                bad++; $display("FAIL race_tick%0d: pos0=%0d state=%0d, want %0d %0d",
                                k, pos_a[10:0], state_a, 4 * k, (k < 5) ? 2 : 3);
            end
        end
        total++;
        if (winner_a !== 1'b0 || wv_a !== 1'b1 || pos_a[21:11] !== 11'd10) begin
            bad++; $display("FAIL race_result: win=%0d wv=%b pos1=%0d, want 0 1 10", winner_a, wv_a, pos_a[21:11]);
        end
    endtask

    task automatic test_tie_clamp();
        countdown_a();
        repeat (2) pulse_a(0, 0, 0, 2'b11);
        repeat (3) pulse_a(0, 0, 1, 2'b00);
        repeat (2) pulse_a(0, 0, 0, 2'b11);
        repeat (3) pulse_a(0, 0, 1, 2'b00);
        total++;
        if (pos_a !== {11'd18, 11'd18}) begin bad++; $display("FAIL tie_pre: pos=%h, want both 18", pos_a); end
        repeat (3) pulse_a(0, 0, 0, 2'b11);
        total++;
        if (gear_a !== {3'd4, 3'd4}) begin bad++; $display("FAIL gear_sat: gear=%h, want both 4", gear_a); end
        pulse_a(0, 0, 1, 2'b00);
        total++;
        if (pos_a !== {11'd20, 11'd20} || state_a !== 2'd3 || winner_a !== 1'b0 || wv_a !== 1'b1) begin
            bad++; $display("FAIL tie_result: pos=%h state=%0d win=%0d wv=%b, want 20/20 3 0 1", pos_a, state_a, winner_a, wv_a);
        end
    endtask

    task automatic test_false_start();
        pulse_a(1, 0, 0, 2'b00);
        pulse_a(0, 0, 1, 2'b00);
        pulse_a(0, 0, 0, 2'b10);
        repeat (7) pulse_a(0, 0, 1, 2'b00);
        total++;
        if (dq_a !== 2'b10 || state_a !== 2'd2) begin bad++; $display("FAIL fs_dq: dq=%b state=%0d, want 10 2", dq_a, state_a); end
        repeat (4) pulse_a(0, 0, 0, 2'b11);
        total++;
        if (gear_a !== {3'd0, 3'd4}) begin bad++; $display("FAIL fs_gear: gear=%h, want %h", gear_a, {3'd0, 3'd4}); end
        repeat (5) pulse_a(0, 0, 1, 2'b11);
        total++;
        if (state_a !== 2'd3 || winner_a !== 1'b0 || wv_a !== 1'b1 || pos_a[21:11] !== 11'd0) begin
            bad++; $display("FAIL fs_result: state=%0d win=%0d wv=%b pos1=%0d, want 3 0 1 0", state_a, winner_a, wv_a, pos_a[21:11]);
        end
        pulse_a(1, 0, 0, 2'b00);
        pulse_a(0, 0, 0, 2'b11);
        repeat (8) pulse_a(0, 0, 1, 2'b00);
        total++;
        if (state_a !== 2'd3 || wv_a !== 1'b0 || dq_a !== 2'b11) begin
            bad++; $display("FAIL fs_all_dq: state=%0d wv=%b dq=%b, want 3 0 11", state_a, wv_a, dq_a);
        end
    endtask

    task automatic test_priority();
        countdown_a();
        pulse_a(1, 0, 0, 2'b00);
        total++;
        if (state_a !== 2'd2 || lights_a !== 2'd3) begin bad++; $display("FAIL start_in_race: state=%0d lights=%0d, want 2 3", state_a, lights_a); end
        pulse_a(0, 0, 0, 2'b01);
        pulse_a(0, 0, 1, 2'b01);
        total++;
        if (pos_a[10:0] !== 11'd1 || gear_a[2:0] !== 3'd2) begin
            bad++; $display("FAIL shift_tick: pos0=%0d gear0=%0d, want 1 2", pos_a[10:0], gear_a[2:0]);
        end
        pulse_a(1, 1, 0, 2'b00);
        total++;
        if ({state_a, lights_a, pos_a, gear_a, dq_a, winner_a, wv_a} !== '0) begin
            bad++; $display("FAIL abort_start: state=%0d pos=%h gear=%h, want all zero", state_a, pos_a, gear_a);
        end
    endtask

    task automatic test_reset_mid();
        countdown_a();
        pulse_a(0, 0, 0, 2'b01);
        pulse_a(0, 0, 1, 2'b00);
        #2 rst = 1'b0;
        #1;
        model_reset();
        total++;
        if ({state_a, lights_a, pos_a, gear_a, dq_a, winner_a, wv_a} !== '0) begin
            bad++; $display("FAIL async_reset: state=%0d pos=%h gear=%h, want all zero", state_a, pos_a, gear_a);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        countdown_a();
        total++;
        if (state_a !== 2'd2 || lights_a !== 2'd3) begin bad++; $display("FAIL post_reset_cd: state=%0d lights=%0d, want 2 3", state_a, lights_a); end
    endtask

    task automatic test_four_players();
        pulse_b(1, 0, 4'b0000);
        repeat (8) pulse_b(0, 1, 4'b0000);
        pulse_b(0, 0, 4'b1010);
        repeat (3) pulse_b(0, 0, 4'b1000);
        repeat (4) pulse_b(0, 1, 4'b0000);
        total++;
        if (state_b !== 2'd2 || pos_b[43:33] !== 11'd16) begin bad++; $display("FAIL p4_mid: state=%0d pos3=%0d, want 2 16", state_b, pos_b[43:33]); end
        pulse_b(0, 1, 4'b0000);
        total++;
        if (state_b !== 2'd3 || winner_b !== 2'd3 || wv_b !== 1'b1 || pos_b[43:33] !== 11'd20 || pos_b[21:11] !== 11'd5) begin
            bad++; $display("FAIL p4_result: state=%0d win=%0d wv=%b pos3=%0d pos1=%0d, want 3 3 1 20 5",
                            state_b, winner_b, wv_b, pos_b[43:33], pos_b[21:11]);
        end
    endtask

    task automatic test_random();
        logic st, ab, tk;
        logic [1:0] sh;
        pulse_a(0, 1, 0, 2'b00);
        for (int c = 0; c < 800; c++) begin
            st = ($urandom_range(0, 14) == 0);
            ab = ($urandom_range(0, 99) == 0);
            tk = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 2; i++)
                sh[i] = (m_state == 1) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) == 0);
            pulse_a(st, ab, tk, sh);
            total++;
            if (state_a !== 2'(m_state) || lights_a !== 2'(model_lights()) ||
                wv_a !== 1'(m_wv) || winner_a !== 1'(m_win)) begin
                bad++; $display("FAIL rnd_ctrl c=%0d: state=%0d lights=%0d wv=%b win=%0d, want %0d %0d %0d %0d",
                                c, state_a, lights_a, wv_a, winner_a, m_state, model_lights(), m_wv, m_win);
            end
            total++;
            if (pos_a !== {11'(m_pos[1]), 11'(m_pos[0])} || gear_a !== {3'(m_gear[1]), 3'(m_gear[0])} ||
                dq_a !== {1'(m_dq[1]), 1'(m_dq[0])}) begin
                bad++; $display("FAIL rnd_lanes c=%0d: pos=%0d/%0d gear=%0d/%0d dq=%b, want %0d/%0d %0d/%0d %0d%0d",
                                c, pos_a[21:11], pos_a[10:0], gear_a[5:3], gear_a[2:0], dq_a,
                                m_pos[1], m_pos[0], m_gear[1], m_gear[0], m_dq[1], m_dq[0]);
            end
        end
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_countdown();
        test_race();
        test_tie_clamp();
        test_false_start();
        test_priority();
        test_reset_mid();
        test_four_players();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/race_ctrl.md
# race_ctrl

Parametrised race controller for the drag-racing game: sequences the start countdown, tracks per-player gear and track position, detects false starts and decides the winner. Sits between the keyboard path (rising-edge key pulses) and the drawing pipeline (car x-positions, countdown lamps), and is kicked off by the menu page controller. Generalises the fixed two-car setup to `NUM_PLAYERS` lanes with configurable track length, gear count and countdown pacing.

## Interface

Parameters:

- `NUM_PLAYERS`, default 2: number of lanes/cars (1..8).
- `POS_W`, default 11: width of one position counter.
- `TRACK_LEN`, default 768: finish position (must be less than 2^POS_W − GEAR_MAX).
- `GEAR_MAX`, default 5: highest gear; gear value equals pixels advanced per frame.
- `COUNT_TICKS`, default 60: frame ticks per countdown lamp step.

Ports:

- `clk` in 1: 65 MHz pixel clock; single clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse from the menu to begin a race.
- `abort` in 1: one-cycle pulse to return to idle.
- `frame_tick` in 1: one-cycle pulse per frame (vsync edge).
- `shift` in NUM_PLAYERS: per-player one-cycle gear-up pulses.
- `state` out 2: race state.
- `lights` out 2: lit countdown lamps (0..3).
- `pos` out NUM_PLAYERS*POS_W: packed positions, lane i at `[i*POS_W +: POS_W]`.
- `gear` out NUM_PLAYERS*GW: packed gears, where GW = clog2(GEAR_MAX+1).
- `dq` out NUM_PLAYERS: per-player false-start flag.
- `winner` out WW: winning lane index, where WW = max(1, clog2(NUM_PLAYERS)).
- `winner_valid` out 1: high in FINISH when a winner exists.

## Operation

- States: IDLE=0, COUNTDOWN=1, RACE=2, FINISH=3.
- Reset values:
  - state=IDLE
  - lights=0
  - all pos=0, gear=0, dq=0
  - winner=0, winner_valid=0
  - internal tick counter=0
- IDLE: on `start`, go to COUNTDOWN. This clears pos, gear, dq, lights, the tick counter and winner_valid.
- COUNTDOWN:
  - Each `frame_tick` increments the tick counter.
  - When the counter is at COUNT_TICKS−1 and a tick arrives, the counter returns to 0 and `lights` increments.
  - When a tick completes the step with lights=3, go to RACE; lights stays 3.
  - A `shift[i]` pulse in COUNTDOWN sets `dq[i]`. The flag is sticky until the next race start.
- RACE:
  - On `frame_tick`, each non-dq lane computes pos_i ← min(pos_i + gear_i, TRACK_LEN).
  - `shift[i]` increments gear_i, saturating at GEAR_MAX. Shifts from dq lanes are ignored; their pos and gear stay 0.
  - Shift and tick in the same cycle: position uses the old gear, and the gear increments on the same edge.
  - Finish: on the edge where any lane's next pos equals TRACK_LEN, go to FINISH. On that edge, winner = lowest-index lane reaching TRACK_LEN and winner_valid=1.
  - All lanes dq at the RACE entry edge: go directly to FINISH with winner_valid=0.
- FINISH:
  - Outputs hold.
  - `start` begins a new COUNTDOWN with the same clearing as from IDLE.
  - `frame_tick` and `shift` are ignored.
- `start` in COUNTDOWN or RACE is ignored.
- `abort` in any state goes to IDLE with the full reset values. `abort` takes priority over `start` and over any simultaneous event.

## Timing

- All outputs are registered. Each event is visible one clock after its input pulse; no combinational input-to-output paths.
- COUNTDOWN length is exactly 4*COUNT_TICKS frame ticks, counted from the first tick after entry.
- The winner decision and the FINISH entry happen on the same edge as the final position update.
- Asynchronous reset assertion mid-race forces reset values immediately. Operation resumes in IDLE after deassertion.
- Arithmetic: the position sum is computed at POS_W+1 bits before clamping, so no wrap-around is possible.

## Structure

- Shared package `race_pkg`: state encodings (`RACE_IDLE`, `RACE_COUNTDOWN`, `RACE_RACE`, `RACE_FINISH`) and `LIGHTS_GO`=3.
- Sub-module `race_lane`, one instance per player via generate. It holds the gear register, position register and dq flag, with inputs for clear, count-enable, race-enable and tick.
- Top-level FSM, tick counter and lowest-index winner priority encoder live in `race_ctrl`.

## Test plan

All scenarios use NUM_PLAYERS=2, COUNT_TICKS=2, TRACK_LEN=20, GEAR_MAX=4 unless noted.

- Countdown: `start`, then 8 frame_ticks → lights steps 1,2,3 after ticks 2,4,6; state=RACE after tick 8; no dq.
- Race: p0 shifts to gear 4, p1 to gear 2, then ticks → p0 pos 4,8,…,20; FINISH on the 5th tick, winner=0, winner_valid=1; p1 pos=10.
- Tie and clamp: both lanes at pos 18, gear 4 (pre-loaded via shifts/ticks), one tick → both pos=20, winner=0. Gear stays 4 after 3 extra shifts.
- False start: `shift[1]` during COUNTDOWN → dq=2'b10; p1 pos stays 0 through RACE; p0 wins. With both lanes dq → FINISH at RACE entry, winner_valid=0.
- Priority and boundaries: `start` during RACE is ignored; `abort`+`start` in the same cycle → IDLE with all outputs zero; shift and tick in the same cycle at gear 1 → pos +1, gear 2.
- Reset: assert `rst` low mid-race → all outputs zero asynchronously; after release, `start` runs a normal countdown. Repeat with NUM_PLAYERS=4 for winner index 3.
